// File: rtl/rv32i_types.sv
// Shared RV32I types for the data-memory path.
//   dmem_state_t : access sequencer state (IDLE, BUSY, DONE)
//   F3_*         : load funct3 encodings used by load extraction
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction and sign/zero extension.
// Ports:
//   word   in  32  raw aligned word from memory
//   offset in  2   byte offset of the effective address
//   funct3 in  3   load type
//   data   out 32  extended load result
module load_extend
  import rv32i_types::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Halfwords are naturally aligned, so only offset[1] picks the half.
    half_sel = offset[1] ? word[31:16] : word[15:0];

    data = word;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      F3_LW:   data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: runs the request/response handshake with the
// data cache, stalls the MEM stage until the cache answers, holds the
// completed access until the pipeline advances, and extends load data.
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_read/req_write            access request from MEM stage
//   req_addr/offset/mbe/wdata     aligned address, byte offset, mask, data
//   load_funct3                   load type
//   advance                       pipeline registers load at this edge
//   dmem_rdata/dmem_resp          cache response
//   dmem_read/write/addr/mbe/wdata registered cache request
//   stall_out                     MEM-stage stall request
//   load_data/load_valid          extended load result
//   timeout_err                   sticky "cache never answered" flag
module dmem_access_unit
  import rv32i_types::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_offset,
  input  logic [3:0]  req_mbe,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  load_funct3,
  input  logic        advance,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] dmem_wdata,
  output logic        stall_out,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  dmem_state_t      state, state_next;
  logic [1:0]       lat_offset;
  logic [2:0]       lat_funct3;
  logic             lat_load;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      ext_data;

  load_extend u_load_extend (
    .word   (dmem_rdata),
    .offset (lat_offset),
    .funct3 (lat_funct3),
    .data   (ext_data)
  );

  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    case (state)
      IDLE: begin
        if (req_read || req_write) begin
          state_next = BUSY;
          stall_out  = 1'b1;
        end
      end
      BUSY: begin
        stall_out = ~dmem_resp;
        if (dmem_resp) state_next = advance ? IDLE : DONE;
      end
      DONE: begin
        if (advance) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dmem_read   <= 1'b0;
      dmem_write  <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_mbe    <= 4'd0;
      dmem_wdata  <= 32'd0;
      lat_offset  <= 2'd0;
      lat_funct3  <= 3'd0;
      lat_load    <= 1'b0;
      cnt         <= '0;
      load_data   <= 32'd0;
      load_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          load_valid <= 1'b0;
          if (req_read || req_write) begin
            // A simultaneous read and write is treated as a write only.
            dmem_read  <= req_read & ~req_write;
            dmem_write <= req_write;
            dmem_addr  <= req_addr;
            dmem_mbe   <= req_mbe;
            dmem_wdata <= req_wdata;
            lat_offset <= req_offset;
            lat_funct3 <= load_funct3;
            lat_load   <= ~req_write;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_mbe   <= 4'd0;
            dmem_wdata <= 32'd0;
            load_valid <= lat_load;
            if (lat_load) load_data <= ext_data;
            cnt        <= '0;
          end else begin
            // Saturate so a very long wait cannot wrap the counter.
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write, advance, dmem_resp;
  logic [31:0] req_addr, req_wdata, dmem_rdata;
  logic [1:0]  req_offset;
  logic [3:0]  req_mbe;
  logic [2:0]  load_funct3;
  logic        dmem_read, dmem_write, stall_out, load_valid, timeout_err;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_mbe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_offset(req_offset), .req_mbe(req_mbe), .req_wdata(req_wdata),
    .load_funct3(load_funct3), .advance(advance),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata), .stall_out(stall_out),
    .load_data(load_data), .load_valid(load_valid), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one access, answer it on the delay-th strobe cycle with advance=1.
  task automatic run_access(
    input logic rd, input logic wr, input logic [31:0] addr, input logic [1:0] off,
    input logic [3:0] mbe, input logic [31:0] wdata, input logic [2:0] f3,
    input logic [31:0] rdata, input int delay,
    output int rd_cnt, output int wr_cnt, output logic [31:0] addr_seen,
    output logic [3:0] mbe_seen, output logic [31:0] wdata_seen);
    int  n;
    bit  done;
    rd_cnt = 0; wr_cnt = 0; addr_seen = 0; mbe_seen = 0; wdata_seen = 0;
    n = 0; done = 0;
    req_read = rd; req_write = wr; req_addr = addr; req_offset = off;
    req_mbe = mbe; req_wdata = wdata; load_funct3 = f3; advance = 1'b0;
    dmem_rdata = 32'hA5A5_A5A5;
    #1;
    check("req_stall", 32'(stall_out), 32'd1);
    for (int c = 0; c < 64 && !done; c++) begin
      step();
      if (dmem_read)  rd_cnt++;
      if (dmem_write) wr_cnt++;
      if (dmem_read || dmem_write) begin
        n++;
        if (n == 1) begin
          addr_seen = dmem_addr; mbe_seen = dmem_mbe; wdata_seen = dmem_wdata;
        end
      end
      if (n == delay) begin
        dmem_resp = 1'b1; dmem_rdata = rdata; advance = 1'b1;
        #1;
        check("resp_stall", 32'(stall_out), 32'd0);
        step();
        dmem_resp = 1'b0; dmem_rdata = 32'h5A5A_5A5A; advance = 1'b0;
        req_read = 1'b0; req_write = 1'b0;
        check("strobe_clear", 32'(dmem_read | dmem_write), 32'd0);
        done = 1;
      end
    end
    if (!done) check("access_wait_bound", 32'd0, 32'd1);
  endtask

  int          rdc, wrc;
  logic [31:0] as, ws;
  logic [3:0]  ms;
  logic [2:0]  t_f3   [8];
  logic [1:0]  t_off  [8];
  logic [31:0] t_rd   [8];
  logic [31:0] t_exp  [8];

  initial begin
    rst = 1'b1; req_read = 0; req_write = 0; req_addr = 0; req_offset = 0;
    req_mbe = 0; req_wdata = 0; load_funct3 = 0; advance = 0;
    dmem_resp = 0; dmem_rdata = 0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_dmem_read", 32'(dmem_read), 32'd0);
    check("rst_dmem_write", 32'(dmem_write), 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);

    // LW, response on third strobe cycle
    run_access(1, 0, 32'h0000_1000, 2'd0, 4'hF, 32'd0, 3'b010, 32'hDEAD_BEEF, 3,
               rdc, wrc, as, ms, ws);
    check("lw_read_cycles", 32'(rdc), 32'd3);
    check("lw_write_cycles", 32'(wrc), 32'd0);
    check("lw_addr", as, 32'h0000_1000);
    check("lw_data", load_data, 32'hDEAD_BEEF);
    check("lw_valid", 32'(load_valid), 32'd1);

    // Extraction table
    t_f3[0] = 3'b000; t_off[0] = 2'd3; t_rd[0] = 32'h80FF_0000; t_exp[0] = 32'hFFFF_FF80;
    t_f3[1] = 3'b100; t_off[1] = 2'd3; t_rd[1] = 32'h80FF_0000; t_exp[1] = 32'h0000_0080;
    t_f3[2] = 3'b001; t_off[2] = 2'd2; t_rd[2] = 32'h80FF_0000; t_exp[2] = 32'hFFFF_80FF;
    t_f3[3] = 3'b101; t_off[3] = 2'd2; t_rd[3] = 32'h80FF_0000; t_exp[3] = 32'h0000_80FF;
    t_f3[4] = 3'b001; t_off[4] = 2'd3; t_rd[4] = 32'h80FF_0000; t_exp[4] = 32'hFFFF_80FF;
    t_f3[5] = 3'b000; t_off[5] = 2'd1; t_rd[5] = 32'h1234_5678; t_exp[5] = 32'h0000_0056;
    t_f3[6] = 3'b010; t_off[6] = 2'd2; t_rd[6] = 32'h1234_5678; t_exp[6] = 32'h1234_5678;
    t_f3[7] = 3'b011; t_off[7] = 2'd1; t_rd[7] = 32'h80FF_0000; t_exp[7] = 32'h80FF_0000;
    for (int i = 0; i < 8; i++) begin
      run_access(1, 0, 32'h0000_0100, t_off[i], 4'hF, 32'd0, t_f3[i], t_rd[i], 1,
                 rdc, wrc, as, ms, ws);
      check($sformatf("ext%0d_data", i), load_data, t_exp[i]);
      check($sformatf("ext%0d_valid", i), 32'(load_valid), 32'd1);
    end

    // SB: single write, load_data holds the last load result
    run_access(0, 1, 32'h0000_3000, 2'd2, 4'b0100, 32'h00AB_0000, 3'b000, 32'hFFFF_FFFF, 1,
               rdc, wrc, as, ms, ws);
    check("sb_write_cycles", 32'(wrc), 32'd1);
    check("sb_read_cycles", 32'(rdc), 32'd0);
    check("sb_mbe", 32'(ms), 32'h4);
    check("sb_wdata", ws, 32'h00AB_0000);
    check("sb_addr", as, 32'h0000_3000);
    check("sb_valid", 32'(load_valid), 32'd0);
    check("sb_data_hold", load_data, 32'h80FF_0000);

    // Read and write together: write wins
    run_access(1, 1, 32'h0000_4000, 2'd0, 4'hF, 32'h1111_2222, 3'b010, 32'h0, 1,
               rdc, wrc, as, ms, ws);
    check("rw_write_cycles", 32'(wrc), 32'd1);
    check("rw_read_cycles", 32'(rdc), 32'd0);

    // Response without advance: hold in DONE, request not re-issued
    req_read = 1; req_addr = 32'h0000_2000; req_offset = 0; load_funct3 = 3'b010;
    req_mbe = 4'hF; advance = 0;
    step();
    check("done_first_read", 32'(dmem_read), 32'd1);
    dmem_resp = 1; dmem_rdata = 32'hCAFE_0001;
    step();
    dmem_resp = 0; dmem_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) dmem_resp = 1;   // stray response must be ignored
      #1;
      check($sformatf("done%0d_read", i), 32'(dmem_read), 32'd0);
      check($sformatf("done%0d_stall", i), 32'(stall_out), 32'd0);
      check($sformatf("done%0d_data", i), load_data, 32'hCAFE_0001);
      check($sformatf("done%0d_valid", i), 32'(load_valid), 32'd1);
      step();
      dmem_resp = 0;
    end
    advance = 1;
    step();
    advance = 0; req_read = 0;
    run_access(1, 0, 32'h0000_2004, 2'd0, 4'hF, 32'd0, 3'b010, 32'h0102_0304, 1,
               rdc, wrc, as, ms, ws);
    check("after_done_data", load_data, 32'h0102_0304);
    check("after_done_reads", 32'(rdc), 32'd1);

    // Timeout after 8 BUSY cycles, then normal completion
    req_read = 1; req_addr = 32'h0000_5000; req_offset = 0; load_funct3 = 3'b010;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("to_cycle%0d_err", i), 32'(timeout_err), 32'd0);
    end
    step();
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_still_read", 32'(dmem_read), 32'd1);
    dmem_resp = 1; dmem_rdata = 32'h1122_3344; advance = 1;
    step();
    dmem_resp = 0; advance = 0; req_read = 0;
    check("to_data", load_data, 32'h1122_3344);
    check("to_valid", 32'(load_valid), 32'd1);
    check("to_read_clear", 32'(dmem_read), 32'd0);
    step();
    check("to_err_sticky", 32'(timeout_err), 32'd1);

    // Reset during BUSY
    req_read = 1; req_addr = 32'h0000_6000; load_funct3 = 3'b010;
    step();
    check("rb_read", 32'(dmem_read), 32'd1);
    req_read = 0;
    #2 rst = 1;
    #1;
    check("rb_read_async", 32'(dmem_read), 32'd0);
    check("rb_stall", 32'(stall_out), 32'd0);
    step();
    rst = 0;
    dmem_resp = 1; dmem_rdata = 32'h7777_7777;
    step();
    dmem_resp = 0;
    check("rb_late_valid", 32'(load_valid), 32'd0);
    check("rb_late_data", load_data, 32'd0);
    check("rb_timeout_clr", 32'(timeout_err), 32'd0);
    run_access(1, 0, 32'h0000_7000, 2'd0, 4'hF, 32'd0, 3'b010, 32'h55AA_33CC, 2,
               rdc, wrc, as, ms, ws);
    check("rb_new_reads", 32'(rdc), 32'd2);
    check("rb_new_data", load_data, 32'h55AA_33CC);
    check("rb_new_valid", 32'(load_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Sits directly downstream of the MEM stage. Consumes its aligned address, byte mask, shifted store data and read/write strobes.
- Runs the request/response handshake with the data cache and stalls the pipeline until the cache responds.
- Holds the completed access until the pipeline advances.
- Extracts and sign/zero-extends load data for the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 1024, BUSY cycles without dmem_resp before the sticky timeout flag sets.
- CNT_W, 11, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_read  input  1  load request from the MEM stage.
- req_write  input  1  store request from the MEM stage.
- req_addr  input  32  word-aligned address (bits [1:0] = 0).
- req_offset  input  2  original byte offset of the effective address.
- req_mbe  input  4  byte enable mask.
- req_wdata  input  32  lane-shifted store data.
- load_funct3  input  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- advance  input  1  pipeline registers load at this edge (global stall is clear).
- dmem_rdata  input  32  cache read data; valid only while dmem_resp=1.
- dmem_resp  input  1  cache completion, one cycle.
- dmem_read  output  1  cache read strobe.
- dmem_write  output  1  cache write strobe.
- dmem_addr  output  32  cache address.
- dmem_mbe  output  4  cache byte enables.
- dmem_wdata  output  32  cache write data.
- stall_out  output  1  MEM-stage stall request.
- load_data  output  32  extended load result.
- load_valid  output  1  load_data is valid.
- timeout_err  output  1  sticky timeout flag.

Behaviour:
- States: IDLE, BUSY, DONE. Reset sets state=IDLE.
- Reset values: all dmem_* outputs 0, load_data=0, load_valid=0, timeout_err=0, counter=0, stall_out=0.
- The dmem_* outputs are registered, driven from the latched request while state=BUSY, and 0 in every other state.
- IDLE:
  - If req_read|req_write: latch addr, mbe, wdata, funct3, offset and kind; go to BUSY; stall_out=1 this cycle.
  - If req_read and req_write are both 1: the write wins and the read is dropped.
  - No request: stall_out=0 and load_valid=0.
- BUSY:
  - stall_out = ~dmem_resp.
  - On dmem_resp: capture the extended load data (loads only), set load_valid for loads, clear the counter.
  - After dmem_resp: if advance=1, go to IDLE; otherwise go to DONE.
  - Without dmem_resp: increment the counter. When it reaches TIMEOUT_CYCLES, set timeout_err. The access continues to wait.
- DONE:
  - stall_out=0; load_data and load_valid hold.
  - The still-present request is not re-issued.
  - On advance=1, go to IDLE.
- Minimum latency:
  - Request in cycle 0, dmem strobe in cycle 1.
  - With resp in cycle 1, stall_out drops in cycle 1 and the pipeline advances at the end of cycle 1.
- Load extraction:
  - LB/LBU: take byte req_offset.
  - LH/LHU: take halfword req_offset[1]; req_offset[0] is ignored.
  - LW: take the whole word; offset ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Any other funct3: pass the word through unchanged.
- dmem_resp while IDLE or DONE: ignored, no state change.
- dmem_rdata is sampled only in the dmem_resp cycle.
- Stores: load_valid stays 0, load_data holds its previous value.
- timeout_err is cleared only by rst.
- Reset mid-access: the registered strobes drop asynchronously, state=IDLE, and a late dmem_resp is ignored.

Decomposition:
- Shared package rv32i_types holds:
  - dmem_state_t enum (IDLE, BUSY, DONE).
  - load_funct3 constants.
- Sub-module load_extend: combinational; inputs word, offset, funct3; output extended 32-bit data. It is reused by any later load-forwarding path.

Test Plan:
- LW to 0x0000_1000, offset 0; resp arrives 3 cycles after the strobe with rdata 0xDEADBEEF -> dmem_read high for exactly 3 cycles; stall_out high until the resp cycle; load_data=0xDEADBEEF; load_valid=1.
- LB offset 3 with rdata 0x80FF_0000 -> load_data=0xFFFF_FF80. LBU at the same offset -> 0x0000_0080. LH offset 2 -> 0xFFFF_80FF. LHU offset 2 -> 0x0000_80FF.
- SB with mbe=0100, wdata=0x00AB_0000, resp after 1 cycle -> dmem_write=1, dmem_mbe=0100, dmem_wdata=0x00AB_0000; load_valid=0; exactly one write issued.
- Resp with advance=0 for 4 cycles while the request stays asserted -> state=DONE; no second dmem_read; stall_out=0; load_data stable; IDLE after advance=1.
- TIMEOUT_CYCLES=8 with no resp -> timeout_err sets after the 8th BUSY cycle and stays set. A later resp completes the access normally.
- Assert rst during BUSY -> dmem_read=0 immediately; a resp in the next cycle produces no load_valid; a new request afterwards completes correctly.
